// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Control and buffering stage that sits between the uart_rx receiver and the
// AXI-lite register front-end.
//   * Owns the receiver's baud prescale. A new value is held in a shadow
//     register and applied only while the receiver is idle, so a frame is
//     never sampled with two different bit periods.
//   * Gates received bytes with a registered enable and buffers them in a
//     show-ahead FIFO.
//   * Flags overrun (byte dropped on a full FIFO) and idle-line timeout
//     (data left unread for 2**TIMEOUT_SHIFT bit-times), and raises a
//     combined, registered interrupt.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   cfg_we          one-cycle strobe, latches cfg_prescale into the shadow
//   cfg_prescale    requested clocks-per-bit (values below 2 clamp to 2)
//   cfg_enable      level, 1 accepts received bytes (one cycle latency)
//   cfg_flush       one-cycle pulse, empties the FIFO
//   status_clr      one-cycle pulse, clears sticky overrun / timeout
//   rx_prescale     prescale currently driven to the receiver
//   rx_data_in      byte from the receiver
//   rx_ready_in     one-cycle valid pulse from the receiver
//   rx_busy_in      receiver is mid-frame
//   m_data          FIFO head byte (valid only while m_valid = 1)
//   m_valid         FIFO not empty
//   m_ready         consumer pop request
//   fifo_count      occupied FIFO entries, 0 .. FIFO_DEPTH
//   pending         a prescale write waits to be applied
//   overrun         sticky, a byte was dropped because the FIFO was full
//   timeout         sticky, data sat idle in the FIFO
//   irq             overrun | timeout | (fifo_count >= WATERMARK)
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 16,
  parameter int ADDR_WIDTH       = 4,
  parameter int DEFAULT_PRESCALE = 868,
  parameter int WATERMARK        = 8,
  parameter int TIMEOUT_SHIFT    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [15:0]           cfg_prescale,
  input  logic                  cfg_enable,
  input  logic                  cfg_flush,
  input  logic                  status_clr,
  output logic [15:0]           rx_prescale,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_ready_in,
  input  logic                  rx_busy_in,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  pending,
  output logic                  overrun,
  output logic                  timeout,
  output logic                  irq
);

  localparam int CNT_W = 16 + TIMEOUT_SHIFT;

  localparam logic [ADDR_WIDTH:0] DEPTH_L     = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] WATERMARK_L = (ADDR_WIDTH + 1)'(WATERMARK);
  localparam logic [ADDR_WIDTH:0] ONE_L       = (ADDR_WIDTH + 1)'(1);
  localparam logic [15:0]         MIN_PRESCALE = 16'd2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                  enable_q;
  logic [15:0]           shadow_q;
  logic                  pending_q;
  logic [15:0]           prescale_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic [CNT_W-1:0]      to_cnt_q;
  logic                  overrun_q;
  logic                  timeout_q;
  logic                  irq_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push_req;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [ADDR_WIDTH:0]   count_nxt;

  logic [CNT_W-1:0]      to_thr;
  logic                  to_clr;
  logic                  to_sat;
  logic                  to_hit;
  logic [CNT_W-1:0]      to_cnt_nxt;

  logic                  overrun_nxt;
  logic                  timeout_nxt;
  logic                  irq_nxt;
  logic [15:0]           prescale_req;

  always_comb begin
    fifo_full  = (count_q == DEPTH_L);
    fifo_empty = (count_q == '0);

    // A pop is only real when there is something at the head.
    pop      = !fifo_empty && m_ready;
    push_req = enable_q && rx_ready_in;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    push     = push_req && (!fifo_full || pop);
    // Flush swallows a colliding byte silently, so it is not an overrun.
    drop     = push_req && fifo_full && !pop && !cfg_flush;

    count_nxt = count_q;
    if (cfg_flush) begin
      count_nxt = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_nxt = count_q + ONE_L;
        2'b01:   count_nxt = count_q - ONE_L;
        default: count_nxt = count_q;
      endcase
    end

    // Idle timeout: count only while data waits and nothing moves.
    to_thr = CNT_W'(prescale_q) << TIMEOUT_SHIFT;
    to_clr = push_req || pop || rx_busy_in || fifo_empty || !enable_q || cfg_flush;
    to_sat = (to_cnt_q == to_thr);
    // Flag on the edge where the counter reaches the threshold, only once, so
    // status_clr can clear timeout while the counter sits saturated.
    to_hit = !to_clr && !to_sat && ((to_cnt_q + CNT_W'(1)) == to_thr);

    if (to_clr) begin
      to_cnt_nxt = '0;
    end else if (to_sat) begin
      to_cnt_nxt = to_cnt_q;
    end else begin
      to_cnt_nxt = to_cnt_q + CNT_W'(1);
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    if (drop) begin
      overrun_nxt = 1'b1;
    end else if (status_clr) begin
      overrun_nxt = 1'b0;
    end else begin
      overrun_nxt = overrun_q;
    end

    if (to_hit) begin
      timeout_nxt = 1'b1;
    end else if (pop || cfg_flush || status_clr) begin
      timeout_nxt = 1'b0;
    end else begin
      timeout_nxt = timeout_q;
    end

    irq_nxt = overrun_nxt || timeout_nxt || (count_nxt >= WATERMARK_L);

    // The receiver cannot sample with fewer than two clocks per bit.
    prescale_req = (cfg_prescale < MIN_PRESCALE) ? MIN_PRESCALE : cfg_prescale;
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q   <= 1'b0;
      shadow_q   <= 16'(DEFAULT_PRESCALE);
      pending_q  <= 1'b0;
      prescale_q <= 16'(DEFAULT_PRESCALE);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      to_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      enable_q <= cfg_enable;

      // Apply the waiting value at the first idle edge. A write landing on
      // that same edge refills the shadow and keeps pending set, so the most
      // recent value is applied at the next idle edge.
      if (pending_q && !rx_busy_in) begin
        prescale_q <= shadow_q;
      end
      if (cfg_we) begin
        shadow_q  <= prescale_req;
        pending_q <= 1'b1;
      end else if (pending_q && !rx_busy_in) begin
        pending_q <= 1'b0;
      end

      if (cfg_flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      end

      count_q   <= count_nxt;
      to_cnt_q  <= to_cnt_nxt;
      overrun_q <= overrun_nxt;
      timeout_q <= timeout_nxt;
      irq_q     <= irq_nxt;
    end
  end

  // FIFO storage carries no reset; contents are only observed through m_valid.
  always_ff @(posedge clk) begin
    if (!rst && push && !cfg_flush) begin
      mem[wr_ptr_q] <= rx_data_in;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rx_prescale = prescale_q;
  assign m_data      = mem[rd_ptr_q];
  assign m_valid     = !fifo_empty;
  assign fifo_count  = count_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl. Bytes accepted by the FIFO are pushed to a
// scoreboard queue when driven and popped/compared when the consumer takes
// them from m_data. Inputs change and outputs are sampled 1 ns after each
// rising edge.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [15:0] cfg_prescale;
  logic        cfg_enable;
  logic        cfg_flush;
  logic        status_clr;
  logic [15:0] rx_prescale;
  logic [7:0]  rx_data_in;
  logic        rx_ready_in;
  logic        rx_busy_in;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  fifo_count;
  logic        pending;
  logic        overrun;
  logic        timeout;
  logic        irq;

  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] sb [$];

  uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_prescale (cfg_prescale),
    .cfg_enable   (cfg_enable),
    .cfg_flush    (cfg_flush),
    .status_clr   (status_clr),
    .rx_prescale  (rx_prescale),
    .rx_data_in   (rx_data_in),
    .rx_ready_in  (rx_ready_in),
    .rx_busy_in   (rx_busy_in),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .fifo_count   (fifo_count),
    .pending      (pending),
    .overrun      (overrun),
    .timeout      (timeout),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Receiver pulse; 'accepted' says whether the byte should land in the FIFO.
  task automatic rx_byte(input logic [7:0] d, input bit accepted);
    rx_data_in  = d;
    rx_ready_in = 1'b1;
    tick();
    rx_ready_in = 1'b0;
    if (accepted) sb.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp_d;
    chk({tag, "_valid"}, m_valid, 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      exp_d = 8'h00;
    end else begin
      exp_d = sb.pop_front();
    end
    chk({tag, "_data"}, m_data, exp_d);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic write_prescale(input logic [15:0] v);
    cfg_prescale = v;
    cfg_we       = 1'b1;
    tick();
    cfg_we       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 0; cfg_prescale = 0; cfg_enable = 0; cfg_flush = 0;
    status_clr = 0; rx_data_in = 0; rx_ready_in = 0; rx_busy_in = 0; m_ready = 0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_prescale", rx_prescale, 868);
    chk("rst_pending",  pending, 0);
    chk("rst_overrun",  overrun, 0);
    chk("rst_timeout",  timeout, 0);
    chk("rst_count",    fifo_count, 0);
    chk("rst_valid",    m_valid, 0);
    chk("rst_irq",      irq, 0);

    // Basic ordering
    cfg_enable = 1'b1;
    tick();
    rx_byte(8'hA5, 1);
    chk("first_visible", m_valid, 1);
    rx_byte(8'h3C, 1);
    rx_byte(8'hFF, 1);
    chk("count3", fifo_count, 3);
    pop_check("pop0");
    pop_check("pop1");
    pop_check("pop2");
    chk("drained_valid", m_valid, 0);
    chk("drained_count", fifo_count, 0);

    // Prescale held while busy
    rx_busy_in = 1'b1;
    write_prescale(16'd434);
    chk("busy_pending", pending, 1);
    chk("busy_prescale", rx_prescale, 868);
    tick(); tick();
    chk("busy_hold", rx_prescale, 868);
    rx_busy_in = 1'b0;
    tick();
    chk("apply_434", rx_prescale, 434);
    chk("apply_pending", pending, 0);
    write_prescale(16'd1);
    chk("clamp_pending", pending, 1);
    tick();
    chk("clamp_2", rx_prescale, 2);
    write_prescale(16'd4);
    tick();
    chk("prescale_4", rx_prescale, 4);

    // Fill, watermark, overrun
    for (int i = 0; i < 16; i++) begin
      rx_byte(8'(i), 1);
      if (i == 6) chk("irq_below_wm", irq, 0);
      if (i == 7) chk("irq_at_wm", irq, 1);
    end
    chk("full_count", fifo_count, 16);
    chk("full_no_ovr", overrun, 0);
    rx_byte(8'h10, 0);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", fifo_count, 16);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Full with simultaneous push and pop
    chk("sim_head", m_data, sb[0]);
    void'(sb.pop_front());
    rx_data_in  = 8'h11;
    rx_ready_in = 1'b1;
    m_ready     = 1'b1;
    tick();
    rx_ready_in = 1'b0;
    m_ready     = 1'b0;
    sb.push_back(8'h11);
    chk("sim_count", fifo_count, 16);
    chk("sim_no_ovr", overrun, 0);
    for (int i = 0; i < 16; i++) pop_check("drain");
    chk("drain_valid", m_valid, 0);

    // Idle timeout: prescale 4 -> 128 clocks
    rx_byte(8'h55, 1);
    repeat (127) tick();
    chk("to_before", timeout, 0);
    tick();
    chk("to_at_128", timeout, 1);
    chk("to_irq", irq, 1);
    pop_check("to_pop");
    chk("to_cleared", timeout, 0);

    // Flush with colliding push
    for (int i = 0; i < 5; i++) rx_byte(8'h20 + 8'(i), 1);
    chk("pre_flush_count", fifo_count, 5);
    rx_data_in  = 8'h77;
    rx_ready_in = 1'b1;
    cfg_flush   = 1'b1;
    tick();
    rx_ready_in = 1'b0;
    cfg_flush   = 1'b0;
    sb.delete();
    chk("flush_count", fifo_count, 0);
    chk("flush_valid", m_valid, 0);
    chk("flush_ovr", overrun, 0);

    // Disabled receive path
    for (int i = 0; i < 4; i++) rx_byte(8'h40 + 8'(i), 1);
    cfg_enable = 1'b0;
    tick();
    rx_byte(8'h99, 0);
    chk("dis_count", fifo_count, 4);
    chk("dis_ovr", overrun, 0);
    chk("dis_to", timeout, 0);
    chk("dis_head", m_data, sb[0]);

    // Reset mid-operation
    rx_busy_in = 1'b1;
    write_prescale(16'd100);
    chk("pre_rst_pending", pending, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx_busy_in = 1'b0;
    sb.delete();
    chk("mid_rst_count",    fifo_count, 0);
    chk("mid_rst_valid",    m_valid, 0);
    chk("mid_rst_prescale", rx_prescale, 868);
    chk("mid_rst_pending",  pending, 0);
    chk("mid_rst_irq",      irq, 0);
    chk("mid_rst_ovr",      overrun, 0);
    chk("mid_rst_to",       timeout, 0);
    rx_byte(8'h5A, 0);
    chk("rst_enable_off", fifo_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
